// File: rtl/sr_latch_bank.sv
// Clocked multi-channel set/reset bank with conflict policy, conflict flag and saturating counter.
// Optional input qualification filter is enabled by defining SR_LATCH_BANK_FILT_EN.
module sr_latch_bank #(
    parameter int               WIDTH     = 8,
    parameter int               PRIORITY  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8,
    parameter int               FILT_CYC  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    generate
        if (PRIORITY < 0 || PRIORITY > 3) begin : g_bad_priority
            $error("sr_latch_bank: PRIORITY must be 0..3");
        end
        if (WIDTH < 1 || CNT_W < 1 || FILT_CYC < 1) begin : g_bad_size
            $error("sr_latch_bank: WIDTH, CNT_W and FILT_CYC must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] s_e;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] both_val;
    logic [WIDTH-1:0] q_next;

`ifdef SR_LATCH_BANK_FILT_EN
    logic [WIDTH-1:0] s_sh [FILT_CYC];
    logic [WIDTH-1:0] r_sh [FILT_CYC];

    // A request is only seen once every stage of its shift register holds a 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < FILT_CYC; k++) begin
                s_sh[k] <= '0;
                r_sh[k] <= '0;
            end
        end else begin
            s_sh[0] <= s;
            r_sh[0] <= r;
            for (int k = 1; k < FILT_CYC; k++) begin
                s_sh[k] <= s_sh[k-1];
                r_sh[k] <= r_sh[k-1];
            end
        end
    end

    always_comb begin
        s_e = '1;
        r_e = '1;
        for (int k = 0; k < FILT_CYC; k++) begin
            s_e = s_e & s_sh[k];
            r_e = r_e & r_sh[k];
        end
    end
`else
    assign s_e = s;
    assign r_e = r;
`endif

    always_comb begin
        both = s_e & r_e;
        case (PRIORITY)
            0:       both_val = '0;
            1:       both_val = '1;
            2:       both_val = q;
            default: both_val = ~q;
        endcase
        q_next = (q & ~(s_e | r_e)) | (s_e & ~r_e) | (both & both_val);
    end

    // Counter counts conflicting cycles, not channels; a same-cycle clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q            <= RESET_VAL;
            qbar         <= ~RESET_VAL;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            q        <= q_next;
            qbar     <= ~q_next;
            conflict <= |both;
            if (cnt_clr) begin
                conflict_cnt <= '0;
            end else if ((|both) && !(&conflict_cnt)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sr_latch_bank.sv
// Scoreboard bench for sr_latch_bank: four PRIORITY variants plus a 2-bit counter variant share stimulus.
// Vectors carry hand-computed post-edge expectations; a negedge monitor pops and compares them.
module tb_sr_latch_bank;

    typedef struct {
        logic [7:0] q0;
        logic [7:0] q1;
        logic [7:0] q2;
        logic [7:0] q3;
        logic       cf;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    typedef struct {
        logic       rstn;
        logic [7:0] s;
        logic [7:0] r;
        logic       clr;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s = '0;
    logic [7:0] r = '0;
    logic       cnt_clr = 1'b0;

    logic [7:0] q0, qb0, q1, qb1, q2, qb2, q3, qb3, qc, qbc;
    logic       cf0, cf1, cf2, cf3, cfc;
    logic [7:0] cnt0, cnt1, cnt3, cntp2;
    logic [1:0] cntc;

    int checks = 0;
    int failures = 0;

    exp_t exp_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    sr_latch_bank #(.WIDTH(8), .PRIORITY(0), .RESET_VAL(8'hA5), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .cnt_clr(cnt_clr),
        .q(q0), .qbar(qb0), .conflict(cf0), .conflict_cnt(cnt0));
    sr_latch_bank #(.WIDTH(8), .PRIORITY(1), .RESET_VAL(8'hA5), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .cnt_clr(cnt_clr),
        .q(q1), .qbar(qb1), .conflict(cf1), .conflict_cnt(cnt1));
    sr_latch_bank #(.WIDTH(8), .PRIORITY(2), .RESET_VAL(8'hA5), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .cnt_clr(cnt_clr),
        .q(q2), .qbar(qb2), .conflict(cf2), .conflict_cnt(cntp2));
    sr_latch_bank #(.WIDTH(8), .PRIORITY(3), .RESET_VAL(8'hA5), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .cnt_clr(cnt_clr),
        .q(q3), .qbar(qb3), .conflict(cf3), .conflict_cnt(cnt3));
    sr_latch_bank #(.WIDTH(8), .PRIORITY(0), .RESET_VAL(8'hA5), .CNT_W(2)) dutc (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .cnt_clr(cnt_clr),
        .q(qc), .qbar(qbc), .conflict(cfc), .conflict_cnt(cntc));

    function automatic void checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endfunction

    task automatic addVec(input logic rstn, input logic [7:0] sv, input logic [7:0] rv, input logic clr,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          input logic [7:0] e3, input logic ecf, input logic [7:0] ecnt,
                          input logic [1:0] ecnt2);
        vec_t v;
        v.rstn = rstn; v.s = sv; v.r = rv; v.clr = clr;
        v.e.q0 = e0; v.e.q1 = e1; v.e.q2 = e2; v.e.q3 = e3;
        v.e.cf = ecf; v.e.cnt = ecnt; v.e.cnt2 = ecnt2;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n   = v.rstn;
        s       = v.s;
        r       = v.r;
        cnt_clr = v.clr;
        @(posedge clk);
        exp_q.push_back(v.e);
    endtask

    // Monitor: outputs only move on posedge, so negedge sampling sees the settled post-edge state.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("q_prio0",    q0,   e.q0);
            checkOutput("qbar_prio0", qb0,  ~e.q0);
            checkOutput("q_prio1",    q1,   e.q1);
            checkOutput("q_prio2",    q2,   e.q2);
            checkOutput("q_prio3",    q3,   e.q3);
            checkOutput("qbar_prio3", qb3,  ~e.q3);
            checkOutput("conflict",   {7'd0, cf0}, {7'd0, e.cf});
            checkOutput("conflict_p3", {7'd0, cf3}, {7'd0, e.cf});
            checkOutput("cnt_w8",     cnt0, e.cnt);
            checkOutput("cnt_w2",     {6'd0, cntc}, {6'd0, e.cnt2});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef SR_LATCH_BANK_FILT_EN
        // FILT_CYC=3: requests need three consecutive high edges, then act one edge later.
        addVec(0, 8'h00, 8'hFF, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h02, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h02, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h02, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h02, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h02, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h00, 8'h00, 0, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 0, 8'd0, 2'd0);
        addVec(1, 8'h00, 8'h00, 0, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 0, 8'd0, 2'd0);
        addVec(1, 8'h08, 8'h00, 0, 8'hA7, 8'hA7, 8'hA7, 8'hA7, 0, 8'd0, 2'd0);
        addVec(0, 8'h08, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h08, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h08, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
`else
        //     rstn s      r      clr  q prio0 prio1  prio2  prio3  cf cnt8   cnt2
        addVec(0, 8'hFF, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'd0, 2'd0);
        addVec(1, 8'h0F, 8'h00, 0, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 0, 8'd0, 2'd0);
        addVec(1, 8'h00, 8'h03, 0, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 0, 8'd0, 2'd0);
        addVec(1, 8'h00, 8'h00, 0, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 0, 8'd0, 2'd0);
        addVec(1, 8'h01, 8'h01, 0, 8'h0C, 8'h0D, 8'h0C, 8'h0D, 1, 8'd1, 2'd1);
        addVec(1, 8'h01, 8'h01, 0, 8'h0C, 8'h0D, 8'h0C, 8'h0C, 1, 8'd2, 2'd2);
        addVec(1, 8'h81, 8'h81, 0, 8'h0C, 8'h8D, 8'h0C, 8'h8D, 1, 8'd3, 2'd3);
        addVec(1, 8'h01, 8'h01, 0, 8'h0C, 8'h8D, 8'h0C, 8'h8C, 1, 8'd4, 2'd3);
        addVec(1, 8'h01, 8'h01, 0, 8'h0C, 8'h8D, 8'h0C, 8'h8D, 1, 8'd5, 2'd3);
        addVec(1, 8'h01, 8'h01, 1, 8'h0C, 8'h8D, 8'h0C, 8'h8C, 1, 8'd0, 2'd0);
        addVec(1, 8'h00, 8'h00, 0, 8'h0C, 8'h8D, 8'h0C, 8'h8C, 0, 8'd0, 2'd0);
        addVec(1, 8'hF0, 8'h0F, 0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 0, 8'd0, 2'd0);
        addVec(1, 8'h02, 8'h02, 0, 8'hF0, 8'hF2, 8'hF0, 8'hF2, 1, 8'd1, 2'd1);
        addVec(0, 8'hFF, 8'hFF, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
        addVec(1, 8'h00, 8'h00, 0, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 8'd0, 2'd0);
`endif
        foreach (vecs[i]) applyStimulus(vecs[i]);
        @(negedge clk);
        rst_n = 1'b1; s = '0; r = '0; cnt_clr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
